z_tile_walker: RTL
==================

// Module: z_tile_walker
// PURPOSE
//  Walks a rectangular pixel tile and streams one interpolated depth per pixel,
//  z(x,y) = offset + x*dzdx + y*dzdy, using forward differences (adders only, no multipliers).
//  Parametrised successor of the fixed 32x32 tile z sweep: configurable tile size and z width,
//  raster or serpentine scan, valid/ready output, busy/done status.
//  Sits between triangle setup (plane coefficients) and the depth-test stage.
// PARAMETERS
//  ZW          27  z / coefficient width in bits; two's complement, all arithmetic mod 2^ZW
//  TW_LOG2     5   log2 of tile width in pixels (tile width W = 2^TW_LOG2)
//  TH_LOG2     5   log2 of tile height in pixels (tile height H = 2^TH_LOG2)
// PORTS
//  clk         in   1        clock; all logic on the rising edge
//  rst         in   1        synchronous reset, active-high
//  start       in   1        launch a tile walk; accepted only when busy==0
//  serp        in   1        scan mode, sampled at start: 0 = raster, 1 = serpentine
//  dzdx_in     in   ZW       z step per +1 x, sampled at start
//  dzdy_in     in   ZW       z step per +1 y, sampled at start
//  offset_in   in   ZW       z at pixel (0,0), sampled at start
//  out_valid   out  1        out_x/out_y/out_z/out_last hold a valid pixel
//  out_ready   in   1        downstream accepts; a pixel transfers when out_valid & out_ready
//  out_x       out  TW_LOG2  pixel x
//  out_y       out  TH_LOG2  pixel y
//  out_z       out  ZW       interpolated z for (out_x,out_y)
//  out_last    out  1        marks the final pixel of the tile
//  busy        out  1        a walk is in progress
//  done        out  1        one-cycle pulse after the last pixel transfers
// BEHAVIOUR
//  Reset: state IDLE. out_valid, out_x, out_y, out_z, out_last, busy and done are all 0.
//   Coefficient registers are cleared. rst has priority over start in the same cycle.
//   rst mid-walk aborts the walk at once; no done pulse is produced.
//  States:
//   IDLE -> RUN      on start (busy==0). Latch dzdx, dzdy, offset and serp.
//                    Load out_x=0, out_y=0, out_z=offset_in. busy=1 from the next cycle.
//   RUN  -> RUN      on each transfer that is not the last: advance one pixel.
//   RUN  -> IDLE     on the transfer with out_last=1: out_valid=0, busy=0, done=1 for one cycle.
//  Latency: start is accepted in cycle N; out_valid=1 in cycle N+1 with pixel (0,0).
//   With out_ready held at 1, W*H consecutive transfers occur in cycles N+1 .. N+W*H,
//   then done=1 in cycle N+W*H+1.
//  Handshake:
//   out_valid is never deasserted while RUN and not yet transferred.
//   While out_valid & !out_ready, all out_* hold stable.
//   out_valid does not depend combinationally on out_ready.
//  Scan order:
//   raster: x counts 0..W-1 on every row, then y increments.
//   serp:   even rows scan x = 0..W-1; odd rows scan x = W-1..0.
//  Forward differences (adds wrap mod 2^ZW, no saturation):
//   Step along a row: z += dzdx (raster, or serp even row); z -= dzdx (serp odd row).
//   Raster row change: x=0, y+=1, z = row_base + dzdy. row_base is the z of x=0 on the current
//    row, updated on each row change.
//   Serp row change: x unchanged (stays at the edge), y+=1, z += dzdy.
//   out_z equals offset + x*dzdx + y*dzdy mod 2^ZW for every emitted pixel.
//  Last pixel: y=H-1 and x=W-1 (raster, or serp with H odd); y=H-1 and x=0 (serp with H even).
//  start while busy is ignored; inputs are not re-latched. start in the cycle done=1 is accepted.
//  out_x and out_y never exceed W-1 and H-1. Counters do not wrap within a walk.
// TESTING
//  T1 TW_LOG2=TH_LOG2=2, raster, dzdx=1, dzdy=4, offset=0, ready=1
//     -> z = 0..15 in order; out_last only on (3,3); done 17 cycles after start.
//  T2 Same coefficients, serp=1
//     -> row1 emits x=3,2,1,0 with z=7,6,5,4; last pixel (0,3) with z=12; 16 transfers.
//  T3 Wrap: ZW=27, offset=0x7FFFFFF, dzdx=1, dzdy=0
//     -> second pixel z=0x0000000; third pixel z=0x0000001.
//  T4 Random out_ready (~50%) over default 32x32, random coefficients
//     -> 1024 transfers, outputs stable while stalled, each z matches the reference formula.
//  T5 start pulsed while busy with different coefficients
//     -> ignored; stream unchanged. start in the done cycle -> new walk begins the next cycle.
//  T6 rst at pixel 5 of a walk
//     -> next cycle out_valid=busy=done=0; no done pulse; a fresh start walks from (0,0).

Source files
------------

// File: rtl/z_tile_walker.sv
// Tile depth walker: streams z = offset + x*dzdx + y*dzdy for every pixel of a
// 2^TW_LOG2 x 2^TH_LOG2 tile, raster or serpentine, using forward differences only.
module z_tile_walker #(
  parameter int ZW      = 27,
  parameter int TW_LOG2 = 5,
  parameter int TH_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               serp,
  input  logic [ZW-1:0]      dzdx_in,
  input  logic [ZW-1:0]      dzdy_in,
  input  logic [ZW-1:0]      offset_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TW_LOG2-1:0] out_x,
  output logic [TH_LOG2-1:0] out_y,
  output logic [ZW-1:0]      out_z,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [TW_LOG2-1:0] X_MAX  = '1;
  localparam logic [TH_LOG2-1:0] Y_MAX  = '1;
  localparam bit                 H_EVEN = (TH_LOG2 > 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q;
  logic [TW_LOG2-1:0]  x_q;
  logic [TH_LOG2-1:0]  y_q;
  logic [ZW-1:0]       z_q;
  logic [ZW-1:0]       row_base_q;
  logic [ZW-1:0]       dzdx_q;
  logic [ZW-1:0]       dzdy_q;
  logic                serp_q;
  logic                done_q;

  logic                odd_row;
  logic                row_end;
  logic                is_last;
  logic [TW_LOG2-1:0]  last_x;
  logic [ZW-1:0]       row_base_d;

  // Odd serpentine rows run right-to-left, so their row ends at x = 0.
  assign odd_row    = serp_q & y_q[0];
  assign row_end    = odd_row ? (x_q == '0) : (x_q == X_MAX);
  assign last_x     = (serp_q && H_EVEN) ? '0 : X_MAX;
  assign is_last    = (y_q == Y_MAX) && (x_q == last_x);
  assign row_base_d = row_base_q + dzdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      row_base_q <= '0;
      dzdx_q     <= '0;
      dzdy_q     <= '0;
      serp_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RUN;
            dzdx_q     <= dzdx_in;
            dzdy_q     <= dzdy_in;
            serp_q     <= serp;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= offset_in;
            row_base_q <= offset_in;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (is_last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              x_q     <= '0;
              y_q     <= '0;
              z_q     <= '0;
            end else if (row_end) begin
              y_q        <= y_q + TH_LOG2'(1);
              row_base_q <= row_base_d;
              // Serpentine turns in place; raster returns to the saved row start.
              if (serp_q) begin
                z_q <= z_q + dzdy_q;
              end else begin
                x_q <= '0;
                z_q <= row_base_d;
              end
            end else if (odd_row) begin
              x_q <= x_q - TW_LOG2'(1);
              z_q <= z_q - dzdx_q;
            end else begin
              x_q <= x_q + TW_LOG2'(1);
              z_q <= z_q + dzdx_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_z     = z_q;
  assign out_last  = (state_q == RUN) & is_last;
  assign done      = done_q;

endmodule
